// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for fp_mult_pipe; master supplies operands and
// accepts results, slave is the multiplier.
interface fp_mult_pipe_if #(
  parameter int BITS = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] X;
  logic [BITS-1:0] Y;
  logic            rnd_mode;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] result;
  logic            inf;
  logic            nan;
  logic            zero;
  logic            overflow;
  logic            underflow;
  logic            inexact;

  modport master (
    output in_valid, X, Y, rnd_mode, out_ready,
    input  in_ready, out_valid, result, inf, nan, zero, overflow, underflow, inexact
  );

  modport slave (
    input  in_valid, X, Y, rnd_mode, out_ready,
    output in_ready, out_valid, result, inf, nan, zero, overflow, underflow, inexact
  );
endinterface

// File: rtl/fp_mult_pipe.sv
// Pipelined floating-point multiplier (RNE or truncate, denormals flushed); 3 cycles
// from acceptance to out_valid; a stalled output freezes every stage and drops in_ready.
module fp_mult_pipe #(
  parameter int EXP  = 8,
  parameter int MAN  = 23,
  parameter int BITS = MAN + EXP + 1,
  parameter int BIAS = 2**(EXP-1) - 1
) (
  input logic           clk,
  input logic           reset_n,
  fp_mult_pipe_if.slave io
);
  localparam int PW = 2*MAN + 2;
  localparam int EW = EXP + 2;

  logic advance;

  logic [EXP-1:0] xe, ye;
  logic [MAN-1:0] xm, ym;
  logic           x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;

  logic           s1_vld, s1_sign, s1_nan, s1_inf, s1_zero, s1_rnd;
  logic [EXP-1:0] s1_xe, s1_ye;
  logic [MAN:0]   s1_xm, s1_ym;

  logic           s2_vld, s2_sign, s2_nan, s2_inf, s2_zero, s2_rnd;
  logic [PW-1:0]  s2_prod;
  logic [EW-1:0]  s2_exp;

  logic           norm, g, r, s, rnd_up, lost, ovf, unf;
  logic [MAN-1:0] frac;
  logic [MAN:0]   frac_r;
  logic [EW-1:0]  exp_n, exp_r;

  logic [BITS-1:0] res_d;
  logic            inf_d, nan_d, zero_d, ovf_d, unf_d, inx_d;

  logic            out_vld_q;
  logic [BITS-1:0] res_q;
  logic            inf_q, nan_q, zero_q, ovf_q, unf_q, inx_q;

  assign advance     = !out_vld_q || io.out_ready;
  assign io.in_ready = advance;

  assign xe = io.X[BITS-2 -: EXP];
  assign ye = io.Y[BITS-2 -: EXP];
  assign xm = io.X[MAN-1:0];
  assign ym = io.Y[MAN-1:0];

  assign x_zero = (xe == '0);
  assign y_zero = (ye == '0);
  assign x_inf  = (&xe) && (xm == '0);
  assign y_inf  = (&ye) && (ym == '0);
  assign x_nan  = (&xe) && (xm != '0);
  assign y_nan  = (&ye) && (ym != '0);

  // Normalise: a product in [2,4) shifts right one place and bumps the exponent.
  always_comb begin
    norm   = s2_prod[PW-1];
    frac   = norm ? s2_prod[2*MAN:MAN+1] : s2_prod[2*MAN-1:MAN];
    g      = norm ? s2_prod[MAN]         : s2_prod[MAN-1];
    r      = norm ? s2_prod[MAN-1]       : s2_prod[MAN-2];
    s      = norm ? (|s2_prod[MAN-2:0])  : (|s2_prod[MAN-3:0]);
    exp_n  = s2_exp + EW'(norm);
    lost   = g | r | s;
    rnd_up = !s2_rnd && g && (r || s || frac[0]);
    frac_r = {1'b0, frac} + (MAN+1)'(rnd_up);
    exp_r  = exp_n + EW'(frac_r[MAN]);
    ovf    = !exp_r[EW-1] && (exp_r >= EW'(2**EXP - 1));
    unf    = exp_r[EW-1] || (exp_r == '0);
  end

  always_comb begin
    res_d  = {s2_sign, exp_r[EXP-1:0], frac_r[MAN-1:0]};
    inf_d  = 1'b0;
    nan_d  = 1'b0;
    zero_d = 1'b0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    inx_d  = lost;
    if (s2_nan) begin
      res_d = {1'b0, {EXP{1'b1}}, 1'b1, {(MAN-1){1'b0}}};
      nan_d = 1'b1;
      inx_d = 1'b0;
    end else if (s2_inf) begin
      res_d = {s2_sign, {EXP{1'b1}}, {MAN{1'b0}}};
      inf_d = 1'b1;
      inx_d = 1'b0;
    end else if (s2_zero) begin
      res_d  = {s2_sign, {(BITS-1){1'b0}}};
      zero_d = 1'b1;
      inx_d  = 1'b0;
    end else if (ovf) begin
      res_d = {s2_sign, {EXP{1'b1}}, {MAN{1'b0}}};
      ovf_d = 1'b1;
      inf_d = 1'b1;
      inx_d = 1'b1;
    end else if (unf) begin
      res_d  = {s2_sign, {(BITS-1){1'b0}}};
      unf_d  = 1'b1;
      zero_d = 1'b1;
      inx_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld    <= 1'b0;
      s1_sign   <= 1'b0;
      s1_nan    <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_rnd    <= 1'b0;
      s1_xe     <= '0;
      s1_ye     <= '0;
      s1_xm     <= '0;
      s1_ym     <= '0;
      s2_vld    <= 1'b0;
      s2_sign   <= 1'b0;
      s2_nan    <= 1'b0;
      s2_inf    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_rnd    <= 1'b0;
      s2_prod   <= '0;
      s2_exp    <= '0;
      out_vld_q <= 1'b0;
      res_q     <= '0;
      inf_q     <= 1'b0;
      nan_q     <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      inx_q     <= 1'b0;
    end else if (advance) begin
      s1_vld    <= io.in_valid;
      s1_sign   <= io.X[BITS-1] ^ io.Y[BITS-1];
      s1_nan    <= x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero);
      s1_inf    <= x_inf || y_inf;
      s1_zero   <= x_zero || y_zero;
      s1_rnd    <= io.rnd_mode;
      s1_xe     <= xe;
      s1_ye     <= ye;
      s1_xm     <= {1'b1, xm};
      s1_ym     <= {1'b1, ym};
      s2_vld    <= s1_vld;
      s2_sign   <= s1_sign;
      s2_nan    <= s1_nan;
      s2_inf    <= s1_inf;
      s2_zero   <= s1_zero;
      s2_rnd    <= s1_rnd;
      s2_prod   <= PW'(s1_xm) * PW'(s1_ym);
      s2_exp    <= EW'(s1_xe) + EW'(s1_ye) - EW'(BIAS);
      out_vld_q <= s2_vld;
      res_q     <= res_d;
      inf_q     <= inf_d;
      nan_q     <= nan_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      inx_q     <= inx_d;
    end
  end

  assign io.out_valid = out_vld_q;
  assign io.result    = res_q;
  assign io.inf       = inf_q;
  assign io.nan       = nan_q;
  assign io.zero      = zero_q;
  assign io.overflow  = ovf_q;
  assign io.underflow = unf_q;
  assign io.inexact   = inx_q;
endmodule
